// File: rtl/mpram_sclk_lvt.sv
// Multi-port single-clock RAM built from NUM_WPORTS x NUM_RPORTS 1W1R banks plus a
// live-value table (LVT) recording which write port last wrote each address.
// Registered reads, lowest-index-wins write conflicts, optional same-cycle bypass and a
// sequenced bulk clear with busy handshake.
// Build option: define MPRAM_INIT_CLEAR_EN to start in the clear sequence after reset.
module mpram_sclk_lvt #(
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NUM_WPORTS    = 4,
  parameter int unsigned NUM_RPORTS    = 2,
  parameter int unsigned ENABLE_BYPASS = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  output logic                             busy,
  input  logic [NUM_WPORTS-1:0]            we,
  input  logic [NUM_WPORTS*ADDR_WIDTH-1:0] waddr,
  input  logic [NUM_WPORTS*DATA_WIDTH-1:0] wdata,
  input  logic [NUM_RPORTS-1:0]            re,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata,
  output logic                             wconflict
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;
  localparam int unsigned LvtW  = (NUM_WPORTS > 1) ? $clog2(NUM_WPORTS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(Depth - 1);

  typedef enum logic [0:0] {StReady, StClear} state_e;

`ifdef MPRAM_INIT_CLEAR_EN
  localparam state_e ResetState = StClear;
`else
  localparam state_e ResetState = StReady;
`endif

  state_e                            state_q, state_d;
  logic [ADDR_WIDTH-1:0]             ptr_q, ptr_d;
  logic [NUM_RPORTS*DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                              wconflict_q, wconflict_d;

  // bank_q[i][j] is written only by write port i and read only by read port j
  logic [DATA_WIDTH-1:0] bank_q [NUM_WPORTS][NUM_RPORTS][Depth];
  logic [LvtW-1:0]       lvt_q  [Depth];

  logic [ADDR_WIDTH-1:0] wa [NUM_WPORTS];
  logic [DATA_WIDTH-1:0] wd [NUM_WPORTS];
  logic [ADDR_WIDTH-1:0] ra [NUM_RPORTS];

  // Unpack the flat port buses into per-port arrays
  always_comb begin
    for (int i = 0; i < NUM_WPORTS; i++) begin
      wa[i] = waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wd[i] = wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int j = 0; j < NUM_RPORTS; j++) begin
      ra[j] = raddr[j*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Clear sequencer: READY <-> CLEAR, pointer walks 0..Depth-1
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StReady: begin
        if (clr) begin
          state_d = StClear;
          ptr_d   = '0;
        end
      end
      StClear: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LastAddr) state_d = StReady;
      end
      default: state_d = StReady;
    endcase
  end

  // Read data: LVT-selected bank, overridden by the lowest-index same-address writer
  always_comb begin
    rdata_d = rdata_q;
    if (state_q == StClear) begin
      rdata_d = '0;
    end else begin
      for (int j = 0; j < NUM_RPORTS; j++) begin
        if (re[j]) begin
          rdata_d[j*DATA_WIDTH +: DATA_WIDTH] = bank_q[lvt_q[ra[j]]][j][ra[j]];
          if (ENABLE_BYPASS != 0) begin
            // Descending scan so the lowest matching port is assigned last
            for (int i = NUM_WPORTS - 1; i >= 0; i--) begin
              if (we[i] && (wa[i] == ra[j])) rdata_d[j*DATA_WIDTH +: DATA_WIDTH] = wd[i];
            end
          end
        end
      end
    end
  end

  // Any pair of enabled write ports hitting the same address is a conflict
  always_comb begin
    wconflict_d = 1'b0;
    if (state_q == StReady) begin
      for (int i = 0; i < NUM_WPORTS; i++) begin
        for (int k = i + 1; k < NUM_WPORTS; k++) begin
          if (we[i] && we[k] && (wa[i] == wa[k])) wconflict_d = 1'b1;
        end
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ResetState;
      ptr_q       <= '0;
      rdata_q     <= '0;
      wconflict_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rdata_q     <= rdata_d;
      wconflict_q <= wconflict_d;
    end
  end

  // Live-value table: lowest-index port wins a same-address conflict
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < Depth; a++) lvt_q[a] <= '0;
    end else if (state_q == StClear) begin
      lvt_q[ptr_q] <= '0;
    end else begin
      // Descending so the lowest index port's assignment takes effect
      for (int i = NUM_WPORTS - 1; i >= 0; i--) begin
        if (we[i]) lvt_q[wa[i]] <= LvtW'(i);
      end
    end
  end

  // Bank storage: no reset so it maps onto plain RAM
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      for (int i = 0; i < NUM_WPORTS; i++) begin
        for (int j = 0; j < NUM_RPORTS; j++) bank_q[i][j][ptr_q] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_WPORTS; i++) begin
        if (we[i]) begin
          for (int j = 0; j < NUM_RPORTS; j++) bank_q[i][j][wa[i]] <= wd[i];
        end
      end
    end
  end

  assign busy      = (state_q == StClear);
  assign rdata     = rdata_q;
  assign wconflict = wconflict_q;

endmodule

// File: tb/tb_mpram_sclk_lvt.sv
// Self-checking bench for mpram_sclk_lvt: directed scenarios plus randomized traffic,
// compared every cycle against an array-based reference model of the memory.
module tb_mpram_sclk_lvt;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NW = 4;
  localparam int NR = 2;
  localparam int Depth = 1 << AW;
  localparam int Bypass = 1;
`ifdef MPRAM_INIT_CLEAR_EN
  localparam bit InitClear = 1'b1;
`else
  localparam bit InitClear = 1'b0;
`endif

  logic             clk, rst, clr, busy, wconflict;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic [NR-1:0]    re;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;

  mpram_sclk_lvt #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .NUM_WPORTS   (NW),
    .NUM_RPORTS   (NR),
    .ENABLE_BYPASS(Bypass)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .busy     (busy),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .re       (re),
    .raddr    (raddr),
    .rdata    (rdata),
    .wconflict(wconflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: logical memory contents as seen by a reader
  logic [DW-1:0] m_mem [Depth];
  logic [DW-1:0] m_rd  [NR];
  bit            m_conf;
  int            m_left, m_ptr;
  int            n_tests, n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    clr = 1'b0; we = '0; re = '0; waddr = '0; wdata = '0; raddr = '0;
  endtask

  task automatic set_w(input int i, input int a, input logic [DW-1:0] d);
    we[i] = 1'b1;
    waddr[i*AW +: AW] = AW'(a);
    wdata[i*DW +: DW] = d;
  endtask

  task automatic set_r(input int j, input int a);
    re[j] = 1'b1;
    raddr[j*AW +: AW] = AW'(a);
  endtask

  function automatic logic [DW-1:0] rd(input int j);
    return rdata[j*DW +: DW];
  endfunction

  task automatic model_reset();
    for (int j = 0; j < NR; j++) m_rd[j] = '0;
    m_conf = 1'b0;
    m_left = InitClear ? Depth : 0;
    m_ptr  = 0;
  endtask

  task automatic check_outputs();
    check("busy", 64'(busy), 64'(m_left > 0));
    check("wconflict", 64'(wconflict), 64'(m_conf));
    for (int j = 0; j < NR; j++) check($sformatf("rdata[%0d]", j), 64'(rd(j)), 64'(m_rd[j]));
  endtask

  // Apply current inputs for one clock, advance the model, compare after the edge
  task automatic cycle();
    logic [DW-1:0] nrd [NR];
    bit            nconf;
    int            a;
    for (int j = 0; j < NR; j++) nrd[j] = m_rd[j];
    nconf = 1'b0;
    if (m_left > 0) begin
      for (int j = 0; j < NR; j++) nrd[j] = '0;
      m_mem[m_ptr] = '0;
      m_ptr++;
      m_left--;
    end else begin
      for (int j = 0; j < NR; j++) begin
        if (re[j]) begin
          a = int'(raddr[j*AW +: AW]);
          nrd[j] = m_mem[a];
          if (Bypass != 0) begin
            for (int i = NW - 1; i >= 0; i--)
              if (we[i] && int'(waddr[i*AW +: AW]) == a) nrd[j] = wdata[i*DW +: DW];
          end
        end
      end
      for (int i = 0; i < NW; i++)
        for (int k = i + 1; k < NW; k++)
          if (we[i] && we[k] && waddr[i*AW +: AW] == waddr[k*AW +: AW]) nconf = 1'b1;
      for (int i = NW - 1; i >= 0; i--)
        if (we[i]) m_mem[int'(waddr[i*AW +: AW])] = wdata[i*DW +: DW];
      if (clr) begin
        m_left = Depth;
        m_ptr  = 0;
      end
    end
    @(posedge clk);
    #1;
    for (int j = 0; j < NR; j++) m_rd[j] = nrd[j];
    m_conf = nconf;
    check_outputs();
  endtask

  task automatic full_clear();
    idle();
    if (m_left == 0) begin
      clr = 1'b1;
      cycle();
      clr = 1'b0;
    end
    while (m_left > 0) cycle();
  endtask

  function automatic int rand_addr();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, Depth - 1))
                                        : int'($urandom_range(0, 7));
  endfunction

  task automatic rand_inputs(input bit allow_clr);
    idle();
    for (int i = 0; i < NW; i++) if ($urandom_range(0, 2) == 0) set_w(i, rand_addr(), $urandom());
    for (int j = 0; j < NR; j++) if ($urandom_range(0, 1) == 0) set_r(j, rand_addr());
    if (allow_clr && $urandom_range(0, 149) == 0) clr = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle();
    rst = 1'b1;
    for (int a = 0; a < Depth; a++) m_mem[a] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_outputs();
    full_clear();

    // Cleared memory reads zero
    idle(); set_r(0, 7); cycle();
    check("read_after_clear", 64'(rd(0)), 64'h0);

    // Simple write then read on another port
    idle(); set_w(2, 5, 32'hCAFEF00D); cycle();
    idle(); set_r(1, 5); cycle();
    check("write_read_p2_p1", 64'(rd(1)), 64'hCAFEF00D);

    // Same-address conflict: lowest index wins, one-cycle pulse
    idle(); set_w(1, 3, 32'h11); set_w(3, 3, 32'h33); cycle();
    check("conflict_pulse", 64'(wconflict), 64'h1);
    idle(); cycle();
    check("conflict_clears", 64'(wconflict), 64'h0);
    idle(); set_r(0, 3); cycle();
    check("conflict_winner", 64'(rd(0)), 64'h11);

    // Two conflicts on different addresses in one cycle
    idle(); set_w(0, 10, 32'h1); set_w(1, 10, 32'h2); set_w(2, 11, 32'h3); set_w(3, 11, 32'h4);
    cycle();
    idle(); cycle();

    // Same-cycle write/read forwarding
    idle(); set_w(0, 9, 32'hA5A5A5A5); set_r(0, 9); cycle();
    check("bypass", 64'(rd(0)), 64'hA5A5A5A5);

    // Fill every address with non-zero data, then bulk clear
    for (int c = 0; c < Depth / NW; c++) begin
      idle();
      for (int i = 0; i < NW; i++) set_w(i, c * NW + i, 32'h1000_0000 | 32'(c * NW + i + 1));
      cycle();
    end
    idle(); clr = 1'b1; cycle();
    for (int n = 0; n < Depth; n++) begin
      rand_inputs(1'b0);
      clr = ($urandom_range(0, 3) == 0);
      cycle();
    end
    check("busy_done", 64'(busy), 64'h0);
    for (int a = 0; a < Depth; a += NR) begin
      idle();
      for (int j = 0; j < NR; j++) set_r(j, a + j);
      cycle();
      for (int j = 0; j < NR; j++) check($sformatf("cleared_%0d", a + j), 64'(rd(j)), 64'h0);
    end

    // rdata holds while re is low
    idle(); set_w(1, 4, 32'h1234); cycle();
    idle(); set_r(0, 4); cycle();
    idle(); repeat (3) cycle();
    check("rdata_hold", 64'(rd(0)), 64'h1234);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      rand_inputs(1'b1);
      cycle();
    end
    full_clear();

    // Reset during clear cycle 10
    idle(); set_w(0, 2, 32'hDEAD); cycle();
    idle(); set_r(0, 2); cycle();
    idle(); clr = 1'b1; cycle();
    idle(); repeat (9) cycle();
    rst = 1'b1;
    #2;
    check("rst_async_busy", 64'(busy), 64'(InitClear));
    check("rst_async_rdata", 64'(rdata), 64'h0);
    check("rst_async_conf", 64'(wconflict), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_outputs();
    full_clear();
    idle(); set_r(0, 7); set_r(1, 20); cycle();

    for (int n = 0; n < 300; n++) begin
      rand_inputs(1'b1);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
